// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the switch-box internal loader.
//   - loader_seq_state_t : states of the frame sequencer
//   - elem_width()       : number of address bits that select an element
//   - local_width()      : number of address bits local to an element
package loader_pkg;

    typedef enum logic [2:0] {
        S_ELEM = 3'd0,
        S_ADDR = 3'd1,
        S_CNT  = 3'd2,
        S_DATA = 3'd3,
        S_SEL  = 3'd4,
        S_GAP  = 3'd5,
        S_DONE = 3'd6
    } loader_seq_state_t;

    function automatic int elem_width(input int nb_elements);
        return $clog2(nb_elements);
    endfunction

    function automatic int local_width(input int address_size, input int nb_elements);
        return address_size - $clog2(nb_elements);
    endfunction

endpackage

// File: rtl/loader_frame_sequencer.sv
// loader_frame_sequencer: parses a byte stream of frames
//   {element, start address, count, count x payload}
// and emits one SELECT strobe per payload byte with ADDRESS/DATA set up a
// cycle ahead and held a cycle after, separated by an idle cycle so every
// strobe is a fresh edge for the downstream loader.
//
// Ports:
//   CLK       clock
//   RESET     synchronous, active-low reset
//   IN_VALID  stream byte valid
//   IN_DATA   stream byte
//   IN_READY  byte can be accepted this cycle (decoded from state only)
//   SELECT    one-cycle strobe toward the loader (registered)
//   ADDRESS   {element, local address} of the current payload byte
//   DATA      current payload byte
//   BUSY      sequencer is inside a frame
//   DONE      one-cycle pulse after a frame completes
//   ERROR     sticky: an element id >= NB_ELEMENTS was seen
module loader_frame_sequencer
    import loader_pkg::*;
#(
    parameter int ADDRESS_SIZE = 9,
    parameter int DATA_SIZE    = 8,
    parameter int NB_ELEMENTS  = 3
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    IN_VALID,
    input  logic [DATA_SIZE-1:0]    IN_DATA,
    output logic                    IN_READY,
    output logic                    SELECT,
    output logic [ADDRESS_SIZE-1:0] ADDRESS,
    output logic [DATA_SIZE-1:0]    DATA,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ERROR
);

    localparam int ELEM_W  = elem_width(NB_ELEMENTS);
    localparam int LOCAL_W = local_width(ADDRESS_SIZE, NB_ELEMENTS);

    // One extra bit so NB_ELEMENTS itself is representable (e.g. 4 with ELEM_W=2).
    localparam logic [ELEM_W:0] ELEM_LIMIT = (ELEM_W + 1)'(NB_ELEMENTS);

    loader_seq_state_t state_q, state_n;

    logic [ELEM_W-1:0]       elem_q, elem_n;
    logic [LOCAL_W-1:0]      addr_q, addr_n;
    logic [DATA_SIZE-1:0]    cnt_q, cnt_n;
    logic                    bad_q, bad_n;
    logic                    select_q, select_n;
    logic [ADDRESS_SIZE-1:0] address_q, address_n;
    logic [DATA_SIZE-1:0]    data_q, data_n;
    logic                    done_q, done_n;
    logic                    error_q, error_n;
    logic                    accept;

    assign IN_READY = (state_q == S_ELEM) || (state_q == S_ADDR) ||
                      (state_q == S_CNT)  || (state_q == S_DATA);
    assign accept   = IN_VALID && IN_READY;

    assign SELECT  = select_q;
    assign ADDRESS = address_q;
    assign DATA    = data_q;
    assign DONE    = done_q;
    assign ERROR   = error_q;
    assign BUSY    = (state_q != S_ELEM);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= S_ELEM;
            elem_q    <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            bad_q     <= 1'b0;
            select_q  <= 1'b0;
            address_q <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            elem_q    <= elem_n;
            addr_q    <= addr_n;
            cnt_q     <= cnt_n;
            bad_q     <= bad_n;
            select_q  <= select_n;
            address_q <= address_n;
            data_q    <= data_n;
            done_q    <= done_n;
            error_q   <= error_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        elem_n    = elem_q;
        addr_n    = addr_q;
        cnt_n     = cnt_q;
        bad_n     = bad_q;
        select_n  = select_q;
        address_n = address_q;
        data_n    = data_q;
        done_n    = 1'b0;
        error_n   = error_q;

        case (state_q)
            S_ELEM: begin
                if (accept) begin
                    elem_n  = IN_DATA[ELEM_W-1:0];
                    state_n = S_ADDR;
                    // A bad frame is still parsed in full to keep the stream aligned.
                    if ({1'b0, IN_DATA[ELEM_W-1:0]} >= ELEM_LIMIT) begin
                        error_n = 1'b1;
                        bad_n   = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (accept) begin
                    addr_n  = IN_DATA[LOCAL_W-1:0];
                    state_n = S_CNT;
                end
            end
            S_CNT: begin
                if (accept) begin
                    cnt_n   = IN_DATA;
                    state_n = (IN_DATA == '0) ? S_DONE : S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    data_n    = IN_DATA;
                    address_n = {elem_q, addr_q};
                    state_n   = S_SEL;
                end
            end
            S_SEL: begin
                select_n = !bad_q;
                state_n  = S_GAP;
            end
            S_GAP: begin
                select_n = 1'b0;
                cnt_n    = cnt_q - DATA_SIZE'(1);
                if (cnt_q == DATA_SIZE'(1)) begin
                    state_n = S_DONE;
                end else begin
                    // Wraps within the element; elem_q is left untouched.
                    addr_n  = addr_q + LOCAL_W'(1);
                    state_n = S_DATA;
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                bad_n   = 1'b0;
                state_n = S_ELEM;
            end
            default: begin
                state_n = S_ELEM;
            end
        endcase
    end

endmodule

// File: tb/tb_loader_frame_sequencer.sv
// Scoreboard bench for loader_frame_sequencer: the stimulus process queues
// hand-computed SELECT and DONE expectations, a negedge monitor pops and
// compares them whenever the DUT strobes.
module tb_loader_frame_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       IN_VALID;
    logic [7:0] IN_DATA;
    logic       IN_READY;
    logic       SELECT;
    logic [8:0] ADDRESS;
    logic [7:0] DATA;
    logic       BUSY;
    logic       DONE;
    logic       ERROR;

    loader_frame_sequencer #(
        .ADDRESS_SIZE(9),
        .DATA_SIZE   (8),
        .NB_ELEMENTS (3)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .IN_VALID(IN_VALID),
        .IN_DATA (IN_DATA),
        .IN_READY(IN_READY),
        .SELECT  (SELECT),
        .ADDRESS (ADDRESS),
        .DATA    (DATA),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERROR   (ERROR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected SELECT beats: {address[8:0], data[7:0]}
    logic [16:0] exp_sel[$];
    // Expected DONE: {latency from last accepted byte, expected ERROR}
    int          exp_done_lat[$];
    logic        exp_done_err[$];

    int last_acc      = 0;
    bit check_spacing = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        IN_VALID = 1'b0;
        repeat (gap) @(negedge CLK);
        IN_VALID = 1'b1;
        IN_DATA  = b;
        guard    = 0;
        while (!IN_READY && guard < 40) begin
            @(negedge CLK);
            guard++;
        end
        if (!IN_READY) begin
            fail_now("ready_timeout");
        end else begin
            @(negedge CLK);
            last_acc = cyc;
        end
        IN_VALID = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input int maxgap);
        foreach (bytes[i]) send_byte(bytes[i], (maxgap == 0) ? 0 : $urandom_range(0, maxgap));
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_done_lat.size() != 0 || exp_sel.size() != 0) && guard < 60) begin
            @(negedge CLK);
            guard++;
        end
        if (exp_done_lat.size() != 0 || exp_sel.size() != 0) fail_now("drain_timeout");
        repeat (2) @(negedge CLK);
    endtask

    task automatic expect_done(input int lat, input logic err);
        exp_done_lat.push_back(lat);
        exp_done_err.push_back(err);
    endtask

    // Monitor
    initial begin
        int          last_sel;
        int          sel_in_frame;
        bit          sel_hold;
        bit          ready_prev;
        logic [8:0]  held_addr;
        logic [7:0]  held_data;
        logic [16:0] e;
        last_sel     = 0;
        sel_in_frame = 0;
        sel_hold     = 1'b0;
        ready_prev   = 1'b0;
        held_addr    = '0;
        held_data    = '0;
        forever begin
            @(negedge CLK);
            if (RESET === 1'b1) begin
                if (sel_hold) begin
                    chk("addr_hold", ADDRESS, held_addr);
                    chk("data_hold", DATA, held_data);
                    sel_hold = 1'b0;
                end
                if (SELECT === 1'b1) begin
                    chk("ready_in_gap", IN_READY, 0);
                    if (exp_sel.size() == 0) begin
                        fail_now("unexpected_select");
                    end else begin
                        e = exp_sel.pop_front();
                        chk("sel_address", ADDRESS, e[16:8]);
                        chk("sel_data", DATA, e[7:0]);
                    end
                    if (check_spacing && sel_in_frame > 0) chk("sel_spacing", cyc - last_sel, 3);
                    last_sel = cyc;
                    sel_in_frame++;
                    held_addr = ADDRESS;
                    held_data = DATA;
                    sel_hold  = 1'b1;
                end
                if (DONE === 1'b1) begin
                    chk("ready_in_done", ready_prev, 0);
                    if (exp_done_lat.size() == 0) begin
                        fail_now("unexpected_done");
                    end else begin
                        chk("done_latency", cyc - last_acc, exp_done_lat.pop_front());
                        chk("done_error", ERROR, exp_done_err.pop_front());
                    end
                    sel_in_frame = 0;
                end
            end else begin
                sel_hold = 1'b0;
            end
            ready_prev = IN_READY;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fr[$];
        RESET    = 1'b0;
        IN_VALID = 1'b0;
        IN_DATA  = 8'h00;
        repeat (2) @(negedge CLK);
        chk("rst_select", SELECT, 0);
        chk("rst_address", ADDRESS, 0);
        chk("rst_data", DATA, 0);
        chk("rst_done", DONE, 0);
        chk("rst_error", ERROR, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_ready", IN_READY, 1);
        RESET = 1'b1;
        @(negedge CLK);

        // Basic frame, valid held high
        check_spacing = 1'b1;
        exp_sel.push_back({9'h085, 8'hAA});
        exp_sel.push_back({9'h086, 8'hBB});
        exp_sel.push_back({9'h087, 8'hCC});
        expect_done(3, 1'b0);
        fr = '{8'h01, 8'h05, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        send_frame(fr, 0);
        wait_drain();
        check_spacing = 1'b0;
        chk("error_clean", ERROR, 0);

        // Local address wrap inside element 2
        exp_sel.push_back({9'h17F, 8'h11});
        exp_sel.push_back({9'h100, 8'h22});
        expect_done(3, 1'b0);
        fr = '{8'h02, 8'h7F, 8'h02, 8'h11, 8'h22};
        send_frame(fr, 0);
        wait_drain();

        // Illegal element: no strobes, but the frame is consumed and completes
        expect_done(3, 1'b1);
        fr = '{8'h03, 8'h00, 8'h02, 8'h11, 8'h22};
        send_frame(fr, 0);
        wait_drain();
        exp_sel.push_back({9'h000, 8'h33});
        expect_done(3, 1'b1);
        fr = '{8'h00, 8'h00, 8'h01, 8'h33};
        send_frame(fr, 0);
        wait_drain();

        // Zero count: DONE one cycle after the count byte
        expect_done(1, 1'b1);
        fr = '{8'h00, 8'h10, 8'h00};
        send_frame(fr, 0);
        wait_drain();

        // Same basic frame with random idle cycles between bytes
        exp_sel.push_back({9'h085, 8'hAA});
        exp_sel.push_back({9'h086, 8'hBB});
        exp_sel.push_back({9'h087, 8'hCC});
        expect_done(3, 1'b1);
        fr = '{8'h01, 8'h05, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        send_frame(fr, 3);
        wait_drain();

        // Reset while in S_SEL (the cycle right after a payload byte is taken)
        fr = '{8'h01, 8'h05, 8'h03, 8'hAA};
        send_frame(fr, 0);
        chk("pre_rst_busy", BUSY, 1);
        RESET = 1'b0;
        @(negedge CLK);
        chk("midrst_select", SELECT, 0);
        chk("midrst_address", ADDRESS, 0);
        chk("midrst_data", DATA, 0);
        chk("midrst_error", ERROR, 0);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_done", DONE, 0);
        RESET = 1'b1;
        repeat (4) @(negedge CLK);

        exp_sel.push_back({9'h085, 8'hAA});
        exp_sel.push_back({9'h086, 8'hBB});
        exp_sel.push_back({9'h087, 8'hCC});
        expect_done(3, 1'b0);
        fr = '{8'h01, 8'h05, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        send_frame(fr, 0);
        wait_drain();

        chk("sel_queue_empty", exp_sel.size(), 0);
        chk("done_queue_empty", exp_done_lat.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
